// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory pipeline stage: FSM state encoding,
// default timeout configuration and the MEM/WB bubble values.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    FAIL = 2'b10
  } mem_state_t;

  localparam int DEFAULT_TIMEOUT_CYCLES = 64;
  localparam int DEFAULT_CNT_W          = 7;

  // A bubble is an instruction that writes nothing and carries zero data.
  localparam logic [15:0] BUBBLE_DATA = 16'h0000;
  localparam logic [2:0]  BUBBLE_REG  = 3'b000;
  localparam logic        BUBBLE_CTRL = 1'b0;

endpackage

// File: rtl/mem_ctrl_fsm.sv
// Memory access controller: tracks outstanding accesses (IDLE/BUSY/FAIL),
// counts BUSY cycles for the timeout, drives stall_mem and selects whether
// MEM/WB captures the current instruction or a bubble. err is sticky.
module mem_ctrl_fsm
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int CNT_W          = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic acc,
  input  logic reject,
  input  logic mem_done,
  output logic stall_mem,
  output logic req_ok,
  output logic capture,
  output logic err
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);

  mem_state_t       state;
  logic [CNT_W-1:0] cnt;

  // State, timeout counter and sticky error update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= CNT_ZERO;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (reject) begin
            err <= 1'b1;
          end else if (acc && !mem_done) begin
            state <= BUSY;
            cnt   <= CNT_ONE;
          end
        end
        BUSY: begin
          if (mem_done) begin
            state <= IDLE;
            cnt   <= CNT_ZERO;
          end else if (cnt == TIMEOUT_CNT) begin
            state <= FAIL;
            err   <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        FAIL: begin
          err <= 1'b1;
        end
        default: begin
          state <= IDLE;
          cnt   <= CNT_ZERO;
        end
      endcase
    end
  end

  // Stall, request enable and MEM/WB capture decisions for the current cycle.
  always_comb begin
    stall_mem = 1'b0;
    req_ok    = 1'b0;
    capture   = 1'b0;
    if (rst) begin
      stall_mem = 1'b0;
      req_ok    = 1'b0;
      capture   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          req_ok = 1'b1;
          if (reject) begin
            capture = 1'b0;
          end else if (acc) begin
            stall_mem = ~mem_done;
            capture   = mem_done;
          end else begin
            capture = 1'b1;
          end
        end
        BUSY: begin
          req_ok    = 1'b1;
          stall_mem = ~mem_done;
          capture   = mem_done;
        end
        FAIL: begin
          stall_mem = 1'b1;
        end
        default: begin
          stall_mem = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/mem_stage_regs.sv
// Basic pipeline register cells used to build the MEM/WB register:
// 16-bit, 3-bit and 1-bit flops with enable and async active-high reset.
module reg16bit (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] d,
  output logic [15:0] q
);
  // Load d when enabled; clear on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 16'h0000;
    end else if (en) begin
      q <= d;
    end
  end
endmodule

module reg3bit (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] d,
  output logic [2:0] q
);
  // Load d when enabled; clear on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 3'b000;
    end else if (en) begin
      q <= d;
    end
  end
endmodule

module dff_en (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d,
  output logic q
);
  // Load d when enabled; clear on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 1'b0;
    end else if (en) begin
      q <= d;
    end
  end
endmodule

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage pipeline: issues loads/stores to a multi-cycle
// data memory, freezes upstream via stall_mem while an access is outstanding
// and owns the MEM/WB register (bubbles during stall cycles).
// Optional build macro: MEM_ALIGN_CHECK_EN rejects accesses to odd addresses
// (err set, no request, bubble). Without it addresses pass through unchecked.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int CNT_W          = DEFAULT_CNT_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ALUO_EXMEM,
  input  logic [15:0] Rd2_EXMEM,
  input  logic [2:0]  WrR_EXMEM,
  input  logic        RegWrite_EXMEM,
  input  logic        MemtoReg_EXMEM,
  input  logic        MemRead_EXMEM,
  input  logic        MemWrite_EXMEM,
  input  logic        Dump_EXMEM,
  input  logic        halt_EXMEM,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        mem_createdump,
  input  logic [15:0] mem_rdata,
  input  logic        mem_done,
  output logic [15:0] ALUO_MEMWB,
  output logic [15:0] MemData_MEMWB,
  output logic [2:0]  WrR_MEMWB,
  output logic        RegWrite_MEMWB,
  output logic        MemtoReg_MEMWB,
  output logic        halt_MEMWB,
  output logic        stall_mem,
  output logic        err
);

  logic acc;
  logic bad;
  logic misalign;
  logic reject;
  logic req_ok;
  logic capture;

  logic [15:0] aluo_d;
  logic [15:0] memdata_d;
  logic [2:0]  wrr_d;
  logic        regwrite_d;
  logic        memtoreg_d;
  logic        halt_d;

  assign acc = MemRead_EXMEM | MemWrite_EXMEM;
  assign bad = MemRead_EXMEM & MemWrite_EXMEM;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = acc & ALUO_EXMEM[0];
`else
  assign misalign = 1'b0;
`endif

  // Any rejected instruction raises err and leaves MEM as a bubble.
  assign reject = bad | misalign;

  // Requests track EX/MEM directly; EX/MEM is frozen while we stall, so
  // address/data/strobes stay stable for the whole access.
  assign mem_addr       = ALUO_EXMEM;
  assign mem_wdata      = Rd2_EXMEM;
  assign mem_rd         = MemRead_EXMEM & req_ok & ~reject;
  assign mem_wr         = MemWrite_EXMEM & req_ok & ~reject;
  assign mem_createdump = Dump_EXMEM & ~stall_mem & ~rst;

  mem_ctrl_fsm #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_fsm (
    .clk      (clk),
    .rst      (rst),
    .acc      (acc),
    .reject   (reject),
    .mem_done (mem_done),
    .stall_mem(stall_mem),
    .req_ok   (req_ok),
    .capture  (capture),
    .err      (err)
  );

  // Next MEM/WB contents: the leaving instruction on capture, else a bubble.
  always_comb begin
    aluo_d     = BUBBLE_DATA;
    memdata_d  = BUBBLE_DATA;
    wrr_d      = BUBBLE_REG;
    regwrite_d = BUBBLE_CTRL;
    memtoreg_d = BUBBLE_CTRL;
    halt_d     = BUBBLE_CTRL;
    if (capture) begin
      aluo_d     = ALUO_EXMEM;
      memdata_d  = MemRead_EXMEM ? mem_rdata : BUBBLE_DATA;
      wrr_d      = WrR_EXMEM;
      regwrite_d = RegWrite_EXMEM;
      memtoreg_d = MemtoReg_EXMEM;
      halt_d     = halt_EXMEM;
    end else begin
      aluo_d = BUBBLE_DATA;
    end
  end

  reg16bit u_aluo    (.clk(clk), .rst(rst), .en(1'b1), .d(aluo_d),     .q(ALUO_MEMWB));
  reg16bit u_memdata (.clk(clk), .rst(rst), .en(1'b1), .d(memdata_d),  .q(MemData_MEMWB));
  reg3bit  u_wrr     (.clk(clk), .rst(rst), .en(1'b1), .d(wrr_d),      .q(WrR_MEMWB));
  dff_en   u_regwrite(.clk(clk), .rst(rst), .en(1'b1), .d(regwrite_d), .q(RegWrite_MEMWB));
  dff_en   u_memtoreg(.clk(clk), .rst(rst), .en(1'b1), .d(memtoreg_d), .q(MemtoReg_MEMWB));
  dff_en   u_halt    (.clk(clk), .rst(rst), .en(1'b1), .d(halt_d),     .q(halt_MEMWB));

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the 5-stage pipeline; consumes the EX/MEM pipeline register outputs and owns the MEM/WB register.
- Issues loads and stores to a multi-cycle data memory (cache/memory system) through a request/done handshake.
- Freezes upstream stages with `stall_mem` while an access is outstanding.
- Inserts bubbles into MEM/WB during stall cycles.

Parameters:
- `TIMEOUT_CYCLES`, default 64: maximum cycles spent in BUSY before the access is declared failed.
- `CNT_W`, default 7: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- ALUO_EXMEM  in  16  ALU result; used as the memory address for loads and stores
- Rd2_EXMEM  in  16  store data
- WrR_EXMEM  in  3  destination register
- RegWrite_EXMEM, MemtoReg_EXMEM, MemRead_EXMEM, MemWrite_EXMEM, Dump_EXMEM, halt_EXMEM  in  1 each  control signals from EX/MEM
- mem_addr  out  16  memory address
- mem_wdata  out  16  memory write data
- mem_rd  out  1  memory read request
- mem_wr  out  1  memory write request
- mem_createdump  out  1  memory dump request
- mem_rdata  in  16  memory read data; valid only when mem_done=1
- mem_done  in  1  one-cycle completion pulse from memory
- ALUO_MEMWB, MemData_MEMWB  out  16 each  MEM/WB register outputs
- WrR_MEMWB  out  3  MEM/WB destination register
- RegWrite_MEMWB, MemtoReg_MEMWB, halt_MEMWB  out  1 each  MEM/WB control outputs
- stall_mem  out  1  freezes PC, IF/ID, ID/EX and EX/MEM when high
- err  out  1  sticky error flag

Behaviour:
- Reset: clock is clk; reset is rst, asynchronous and active-high.
  - FSM goes to IDLE and the timeout counter to 0.
  - All MEM/WB outputs go to 0; err goes to 0.
  - stall_mem, mem_rd, mem_wr and mem_createdump are 0 while rst is high.
- Access definition: `acc = MemRead_EXMEM | MemWrite_EXMEM`.
- Request outputs:
  - `mem_addr = ALUO_EXMEM` and `mem_wdata = Rd2_EXMEM`, both combinational.
  - `mem_rd = MemRead_EXMEM` and `mem_wr = MemWrite_EXMEM`, both gated by `(state==IDLE | state==BUSY) & ~bad`.
- Illegal combination: `bad = MemRead_EXMEM & MemWrite_EXMEM`.
  - err is set, no request is issued, and the instruction becomes a bubble.
- FSM states: IDLE, BUSY, FAIL.
  - IDLE, no access: MEM/WB loads EX/MEM values with `MemData_MEMWB = 0`; `stall_mem = 0`.
  - IDLE, access with mem_done in the same cycle (hit, 0 stall cycles): MEM/WB loads `MemData_MEMWB = mem_rdata` (0 for a store); stay in IDLE; `stall_mem = 0`.
  - IDLE, access without mem_done: go to BUSY; counter = 1; `stall_mem = 1`; MEM/WB loads a bubble.
  - BUSY: mem_rd/mem_wr, address and data are held stable, because upstream is frozen.
    - `stall_mem = ~mem_done`.
    - Each non-done cycle loads a bubble into MEM/WB and increments the counter.
    - When mem_done arrives, MEM/WB captures the result and the FSM returns to IDLE; the next instruction presents on the following cycle.
  - BUSY with counter == TIMEOUT_CYCLES and no mem_done: go to FAIL.
  - FAIL: err = 1; stall_mem = 1; requests are dropped; MEM/WB holds bubbles. FAIL exits only on rst.
- Bubble definition: RegWrite_MEMWB=0, MemtoReg_MEMWB=0, halt_MEMWB=0, WrR_MEMWB=0, data outputs = 0.
- mem_done received in IDLE with no access: ignored.
- Memory latency: access latency is 1 cycle for a hit and N+1 cycles for a miss, where N = stall cycles.
- Dump: `mem_createdump = Dump_EXMEM & ~stall_mem`, so it pulses exactly once per instruction.
- halt_MEMWB propagates only on the cycle the instruction leaves MEM, never duplicated across stall cycles.
- err is sticky until rst.
- Reset mid-BUSY: requests drop asynchronously; the memory system shares rst, so no stale mem_done follows.

Optional Feature:
- Macro: `MEM_ALIGN_CHECK_EN`.
- Defined: an access with `ALUO_EXMEM[0] = 1` sets err, issues no request, and enters MEM/WB as a bubble.
- Undefined: no alignment check; the address is passed to memory unchanged.

Decomposition:
- Shared package `mem_stage_pkg`: FSM state encoding (IDLE=2'b00, BUSY=2'b01, FAIL=2'b10), default TIMEOUT_CYCLES, bubble constants.
- Sub-module `mem_ctrl_fsm`: state, timeout counter, stall_mem, capture/bubble select.
- Top level: request muxing plus the MEM/WB registers, built from existing reg16bit/reg3bit/dff_en instances with en=1'b1.

Test Plan:
1. Load hit: MemRead=1, ALUO=0x0010, mem_done=1 with mem_rdata=0xBEEF in the same cycle -> stall_mem never 1; next cycle MemData_MEMWB=0xBEEF, RegWrite_MEMWB=1, MemtoReg_MEMWB=1.
2. Load miss: mem_done three cycles after the request, mem_rdata=0x1234 -> stall_mem=1 for 3 cycles; MEM/WB bubbles (RegWrite_MEMWB=0) in those cycles; then MemData_MEMWB=0x1234; mem_rd stays stable throughout.
3. Store miss: MemWrite=1, ALUO=0x0020, Rd2=0x5A5A, done after 2 cycles -> mem_wr=1, mem_addr=0x0020, mem_wdata=0x5A5A held for 3 cycles; RegWrite_MEMWB=0 throughout.
4. ALU op: ALUO=0x00AA, RegWrite=1, WrR=3'd5 -> next cycle ALUO_MEMWB=0x00AA, WrR_MEMWB=5; mem_rd=mem_wr=0.
5. Timeout: load with mem_done never asserted -> after 64 BUSY cycles err=1 and stall_mem=1, both held until rst; after rst all outputs are 0.
6. rst asserted in cycle 2 of BUSY -> immediate IDLE; mem_rd=0; MEM/WB=0. With MEM_ALIGN_CHECK_EN: load at 0x0011 -> err=1 and no mem_rd.
